// File: rtl/debounce_sync.sv
// debounce_sync
//
// Synchronizes a raw asynchronous level into the clk domain and debounces it
// with a counter-qualified one-hot Moore FSM. The registered, glitch-free
// result feeds the downstream dual-edge detector.
//
// Parameters:
//   SYNC_STAGES   synchronizer depth (>= 2)
//   STABLE_COUNT  extra consecutive equal samples needed after leaving a
//                 stable state before a new level is accepted (>= 1)
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   din         raw asynchronous input level
//   dout        debounced level (registered)
//   settling    high while a candidate level change is being qualified
//   glitch_cnt  saturating count of rejected transitions (0 when disabled)
//   state_dbg   current one-hot FSM state, for observation only
//
// Build option:
//   DEBOUNCE_GLITCH_CNT_EN  when defined, glitch_cnt is an 8-bit saturating
//                           counter; otherwise it is tied to zero.
module debounce_sync #(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_COUNT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic       dout,
    output logic       settling,
    output logic [7:0] glitch_cnt,
    output logic [3:0] state_dbg
);

    localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

    typedef enum logic [3:0] {
        STABLE_LOW  = 4'b0001,
        QUAL_HIGH   = 4'b0010,
        STABLE_HIGH = 4'b0100,
        QUAL_LOW    = 4'b1000
    } state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   dout_nxt;
    logic                   settling_nxt;

    // Synchronizer chain; only the last stage is visible to the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= STABLE_LOW;
            cnt      <= '0;
            dout     <= 1'b0;
            settling <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dout     <= dout_nxt;
            settling <= settling_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            STABLE_LOW: begin
                if (sync_q) begin
                    state_nxt = QUAL_HIGH;
                    cnt_nxt   = '0;
                end
            end
            QUAL_HIGH: begin
                if (!sync_q) begin
                    state_nxt = STABLE_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_HIGH;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!sync_q) begin
                    state_nxt = QUAL_LOW;
                    cnt_nxt   = '0;
                end
            end
            QUAL_LOW: begin
                if (sync_q) begin
                    state_nxt = STABLE_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_LOW;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                // Any non-one-hot code falls back to the reset state.
                state_nxt = STABLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are ready in the same
    // flop stage as the state register; dout holds its old level while qualifying.
    assign dout_nxt     = (state_nxt == STABLE_HIGH) || (state_nxt == QUAL_LOW);
    assign settling_nxt = (state_nxt == QUAL_HIGH) || (state_nxt == QUAL_LOW);

    assign state_dbg = state;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic reject;

    // A qualification aborted by the level reverting is a glitch.
    assign reject = ((state == QUAL_HIGH) && !sync_q) ||
                    ((state == QUAL_LOW)  &&  sync_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_cnt <= 8'h00;
        end else if (reject && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'h01;
        end
    end
`else
    assign glitch_cnt = 8'h00;
`endif

endmodule
